defl_arb_stage: RTL and testbench

//   Registered two-flit deflection arbitration stage for the MinBD router permutation network.

---
 rtl/minbd_pkg.sv | 32 +++
 rtl/lfsr16.sv | 27 ++
 rtl/defl_arb_stage.sv | 106 ++++++++++
 tb/tb_defl_arb_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/minbd_pkg.sv
// Shared flit format and ranking helper for the MinBD router stages.
package minbd_pkg;

  localparam int FLIT_W = 11;
  localparam int GOLD_B = 10;
  localparam int VAL_B  = 9;
  localparam int DST_HI = 8;
  localparam int DST_LO = 6;
  localparam int ID_HI  = 5;
  localparam int ID_LO  = 0;

  localparam logic [2:0] DST_OUT1 = 3'b000;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic [1:0] {
    RANK_EMPTY  = 2'd0,
    RANK_VALID  = 2'd1,
    RANK_GOLDEN = 2'd2
  } rank_e;

  // Expects a flit whose gold bit has already been tagged (and cleared when invalid).
  function automatic rank_e flit_rank(input flit_t f);
    if (!f[VAL_B])
      return RANK_EMPTY;
    else if (f[GOLD_B])
      return RANK_GOLDEN;
    else
      return RANK_VALID;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), shared by the router stages for tie-breaking.
module lfsr16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] r_q;
  logic        w_fb;
  logic [15:0] w_seed;

  assign w_fb = r_q[15] ^ r_q[13] ^ r_q[12] ^ r_q[10];
  // An all-zero seed would lock the register, so substitute a legal state.
  assign w_seed = (seed == 16'h0000) ? 16'h0001 : seed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_q <= w_seed;
    else if (en)
      r_q <= {r_q[14:0], w_fb};
  end

  assign q = r_q;

endmodule

// File: rtl/defl_arb_stage.sv
// Two-flit deflection arbitration stage: golden tagging, rank/steer, registered outputs
// and a saturating deflection counter.
module defl_arb_stage
  import minbd_pkg::*;
#(
  parameter int          EPOCH_LEN = 64,
  parameter int          ID_W      = 6,
  parameter int          CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [10:0]       inp1,
  input  logic [10:0]       inp2,
  output logic [10:0]       out1,
  output logic [10:0]       out2,
  output logic [ID_W-1:0]   golden_id,
  output logic [CNT_W-1:0]  deflect_cnt
);

  localparam int EP_W = (EPOCH_LEN > 2) ? $clog2(EPOCH_LEN) : 1;
  localparam logic [EP_W-1:0] EP_LAST = EP_W'(EPOCH_LEN - 1);

  // en is a stage-wide advance with no backpressure: a flit pair is consumed on
  // every edge with en=1, and with en=0 every register in the stage holds.
  logic [EP_W-1:0]  r_epoch;
  logic [ID_W-1:0]  r_golden_id;
  logic [CNT_W-1:0] r_cnt;
  flit_t            r_out1;
  flit_t            r_out2;

  logic [15:0] w_lfsr;
  logic        w_a_gold;
  logic        w_b_gold;
  flit_t       w_a_tag;
  flit_t       w_b_tag;
  rank_e       w_a_rank;
  rank_e       w_b_rank;
  logic        w_a_wins;
  flit_t       w_win;
  flit_t       w_lose;
  logic        w_win_to_out1;
  logic        w_lose_pref1;
  logic        w_deflect;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .seed  (LFSR_SEED),
    .q     (w_lfsr)
  );

  // Golden is sticky on the incoming bit and never survives on an empty slot.
  assign w_a_gold = inp1[VAL_B] & ((inp1[ID_HI:ID_LO] == r_golden_id) | inp1[GOLD_B]);
  assign w_b_gold = inp2[VAL_B] & ((inp2[ID_HI:ID_LO] == r_golden_id) | inp2[GOLD_B]);
  assign w_a_tag  = {w_a_gold, inp1[VAL_B:0]};
  assign w_b_tag  = {w_b_gold, inp2[VAL_B:0]};

  assign w_a_rank = flit_rank(w_a_tag);
  assign w_b_rank = flit_rank(w_b_tag);
  assign w_a_wins = (w_a_rank > w_b_rank) || ((w_a_rank == w_b_rank) && !w_lfsr[0]);

  assign w_win  = w_a_wins ? w_a_tag : w_b_tag;
  assign w_lose = w_a_wins ? w_b_tag : w_a_tag;

  assign w_win_to_out1 = (w_win[DST_HI:DST_LO] == DST_OUT1);
  assign w_lose_pref1  = (w_lose[DST_HI:DST_LO] == DST_OUT1);
  // The loser lands on out1 exactly when the winner took out2.
  assign w_deflect     = w_lose[VAL_B] && (w_win_to_out1 == w_lose_pref1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_epoch     <= '0;
      r_golden_id <= '0;
      r_cnt       <= '0;
      r_out1      <= '0;
      r_out2      <= '0;
    end else if (en) begin
      if (r_epoch == EP_LAST) begin
        r_epoch     <= '0;
        r_golden_id <= r_golden_id + 1'b1;
      end else begin
        r_epoch <= r_epoch + 1'b1;
      end

      if (w_win_to_out1) begin
        r_out1 <= w_win;
        r_out2 <= w_lose;
      end else begin
        r_out1 <= w_lose;
        r_out2 <= w_win;
      end

      if (w_deflect && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign out1        = r_out1;
  assign out2        = r_out2;
  assign golden_id   = r_golden_id;
  assign deflect_cnt = r_cnt;

endmodule

// File: tb/tb_defl_arb_stage.sv
// Directed bench for defl_arb_stage: a default-parameter instance and a short-epoch,
// 4-bit-counter instance share the same stimulus.
module tb_defl_arb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [10:0] inp1 = '0;
  logic [10:0] inp2 = '0;

  logic [10:0] out1, out2, s_out1, s_out2;
  logic [5:0]  golden_id, s_golden_id;
  logic [15:0] deflect_cnt;
  logic [3:0]  s_deflect_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [10:0] exp_q[$];

  typedef struct {
    logic [10:0] in1;
    logic [10:0] in2;
    logic [10:0] e_out1;
    logic [10:0] e_out2;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[9];

  defl_arb_stage u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .inp1        (inp1),
    .inp2        (inp2),
    .out1        (out1),
    .out2        (out2),
    .golden_id   (golden_id),
    .deflect_cnt (deflect_cnt)
  );

  defl_arb_stage #(.EPOCH_LEN(4), .CNT_W(4)) u_small (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .inp1        (inp1),
    .inp2        (inp2),
    .out1        (s_out1),
    .out2        (s_out2),
    .golden_id   (s_golden_id),
    .deflect_cnt (s_deflect_cnt)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [10:0] a, input logic [10:0] b, input logic e);
    inp1 = a;
    inp2 = b;
    en   = e;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    inp1  = '0;
    inp2  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  initial begin
    logic [15:0] lfsr_m;
    logic [10:0] e;
    int          wins_a;

    //               in1      in2      out1     out2     cnt
    tbl[0] = '{11'h205, 11'h000, 11'h205, 11'h000, 16'd0}; // single A, dst0
    tbl[1] = '{11'h285, 11'h000, 11'h000, 11'h285, 16'd0}; // single A, dst2
    tbl[2] = '{11'h000, 11'h205, 11'h205, 11'h000, 16'd0}; // single B, dst0
    tbl[3] = '{11'h000, 11'h2C3, 11'h000, 11'h2C3, 16'd0}; // single B, dst3
    tbl[4] = '{11'h400, 11'h285, 11'h000, 11'h285, 16'd0}; // gold bit on empty cleared
    tbl[5] = '{11'h605, 11'h203, 11'h605, 11'h203, 16'd1}; // sticky gold A beats B
    tbl[6] = '{11'h283, 11'h641, 11'h283, 11'h641, 16'd2}; // gold B to out2, A deflected
    tbl[7] = '{11'h203, 11'h280, 11'h203, 11'h680, 16'd2}; // id0 tagged golden, no conflict
    tbl[8] = '{11'h2C1, 11'h6C2, 11'h2C1, 11'h6C2, 16'd3}; // both want out2

    // Reset held with a valid input present
    rst_n = 1'b0;
    inp1  = 11'h2C5;
    en    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out1", 16'(out1), 16'h0);
    chk("rst_out2", 16'(out2), 16'h0);
    chk("rst_gid", 16'(golden_id), 16'h0);
    chk("rst_cnt", deflect_cnt, 16'h0);
    chk("rst_small_cnt", 16'(s_deflect_cnt), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    inp1  = '0;
    en    = 1'b0;

    // Table-driven vectors (golden_id stays 0 throughout)
    for (int i = 0; i < 9; i++) begin
      apply(tbl[i].in1, tbl[i].in2, 1'b1);
      chk($sformatf("vec%0d_out1", i), 16'(out1), 16'(tbl[i].e_out1));
      chk($sformatf("vec%0d_out2", i), 16'(out2), 16'(tbl[i].e_out2));
      chk($sformatf("vec%0d_cnt", i), deflect_cnt, tbl[i].e_cnt);
      chk($sformatf("vec%0d_gid", i), 16'(golden_id), 16'h0);
    end

    // Async reset mid-cycle clears state before the next edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out1", 16'(out1), 16'h0);
    chk("async_out2", 16'(out2), 16'h0);
    chk("async_cnt", deflect_cnt, 16'h0);
    do_reset();

    // Golden priority on the short-epoch instance: golden_id=5 after 20 edges
    for (int i = 0; i < 20; i++) apply(11'h000, 11'h000, 1'b1);
    chk("gold_gid", 16'(s_golden_id), 16'd5);
    apply(11'h245, 11'h247, 1'b1);
    chk("gold_out2", 16'(s_out2), 16'h645);
    chk("gold_out1", 16'(s_out1), 16'h247);
    chk("gold_cnt", 16'(s_deflect_cnt), 16'd1);

    // Stall: en low holds everything
    for (int i = 0; i < 3; i++) begin
      apply(11'h205, 11'h203, 1'b0);
      chk("stall_out1", 16'(s_out1), 16'h247);
      chk("stall_out2", 16'(s_out2), 16'h645);
      chk("stall_gid", 16'(s_golden_id), 16'd5);
      chk("stall_cnt", 16'(s_deflect_cnt), 16'd1);
    end
    // Epoch counter was frozen at 1: two more edges keep id 5, the third wraps to 6
    apply(11'h000, 11'h000, 1'b1);
    chk("resume_gid_a", 16'(s_golden_id), 16'd5);
    chk("resume_out1", 16'(s_out1), 16'h0);
    apply(11'h000, 11'h000, 1'b1);
    chk("resume_gid_b", 16'(s_golden_id), 16'd5);
    apply(11'h000, 11'h000, 1'b1);
    chk("resume_gid_c", 16'(s_golden_id), 16'd6);

    // Epoch wrap through 63 -> 0
    do_reset();
    for (int n = 1; n <= 260; n++) begin
      apply(11'h000, 11'h000, 1'b1);
      chk($sformatf("epoch_gid_%0d", n), 16'(s_golden_id), 16'((n / 4) % 64));
    end

    // Counter saturation at 15 under continuous conflicts
    do_reset();
    for (int n = 1; n <= 20; n++) begin
      apply(11'h205, 11'h203, 1'b1);
      chk($sformatf("sat_cnt_%0d", n), 16'(s_deflect_cnt), 16'((n > 15) ? 15 : n));
    end

    // Tie-break sequence against the reference LFSR
    do_reset();
    lfsr_m = 16'hACE1;
    wins_a = 0;
    for (int i = 0; i < 1000; i++) begin
      exp_q.push_back(lfsr_m[0] ? 11'h23F : 11'h23E);
      apply(11'h23E, 11'h23F, 1'b1);
      lfsr_m = lfsr_next(lfsr_m);
      e = exp_q.pop_front();
      chk($sformatf("tie_out1_%0d", i), 16'(out1), 16'(e));
      chk($sformatf("tie_out2_%0d", i), 16'(out2), 16'(e ^ 11'h001));
      chk($sformatf("tie_cnt_%0d", i), deflect_cnt, 16'(i + 1));
      if (out1 == 11'h23E) wins_a++;
    end
    chk("tie_balance", 16'((wins_a >= 400 && wins_a <= 600) ? 1 : 0), 16'd1);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
